// File: rtl/svc_pkg.sv
// Shared types and defaults for the service counter bank: lane state encoding,
// default geometry and the per-lane bus slicing helper.
package svc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } lane_state_t;

    localparam int DEF_DT_SZ    = 4;
    localparam int DEF_CNTER    = 3;
    localparam int DEF_TICK_DIV = 4;

    // Low bit index of a lane's field in a flattened CNTER*width bus.
    function automatic int slice_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/service_lane.sv
// One service window: latches ticket/service time on load, counts down on the
// shared tick, pulses done. Optional sticky ld_err when SVC_OVERLOAD_DET_EN is defined.
module service_lane
    import svc_pkg::*;
#(
    parameter int DT_SZ = DEF_DT_SZ
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             ld,
    input  logic [DT_SZ-1:0] dn,
    input  logic [DT_SZ-1:0] dt,
    output logic             busy,
    output logic             done,
    output logic [DT_SZ-1:0] cur_num,
`ifdef SVC_OVERLOAD_DET_EN
    output logic             ld_err,
`endif
    output logic [DT_SZ-1:0] remain
);

    lane_state_t state;

    // rst_n is active-high here: the lane aborts without a done pulse.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            cur_num <= '0;
            remain  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld) begin
                        cur_num <= dn;
                        remain  <= dt;
                        busy    <= 1'b1;
                        if (dt != '0) begin
                            state <= SERVE;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SERVE: begin
                    if (tick) begin
                        remain <= remain - 1'b1;
                        if (remain == DT_SZ'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SVC_OVERLOAD_DET_EN
    // A load is only legal in IDLE; anything else latches the error until reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ld_err <= 1'b0;
        end else if (ld && (state != IDLE)) begin
            ld_err <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/service_counter_bank.sv
// Bank of CNTER independent service lanes sharing one tick prescaler.
// Define SVC_OVERLOAD_DET_EN to add the sticky per-lane ld_err output.
module service_counter_bank
    import svc_pkg::*;
#(
    parameter int DT_SZ    = DEF_DT_SZ,
    parameter int CNTER    = DEF_CNTER,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CNTER-1:0]       ld,
    input  logic [CNTER*DT_SZ-1:0] dn,
    input  logic [CNTER*DT_SZ-1:0] dt,
    output logic [CNTER-1:0]       busy,
    output logic [CNTER-1:0]       done,
    output logic [CNTER*DT_SZ-1:0] cur_num,
`ifdef SVC_OVERLOAD_DET_EN
    output logic [CNTER-1:0]       ld_err,
`endif
    output logic [CNTER*DT_SZ-1:0] remain
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] pre_cnt;
    logic          tick;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pre_cnt <= '0;
        end else if (pre_cnt == LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    assign tick = (pre_cnt == LAST);

    for (genvar g = 0; g < CNTER; g++) begin : g_lane
        localparam int LO = slice_lo(g, DT_SZ);

        service_lane #(
            .DT_SZ(DT_SZ)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick   (tick),
            .ld     (ld[g]),
            .dn     (dn[LO +: DT_SZ]),
            .dt     (dt[LO +: DT_SZ]),
            .busy   (busy[g]),
            .done   (done[g]),
            .cur_num(cur_num[LO +: DT_SZ]),
`ifdef SVC_OVERLOAD_DET_EN
            .ld_err (ld_err[g]),
`endif
            .remain (remain[LO +: DT_SZ])
        );
    end

endmodule

// File: doc/service_counter_bank.md
Name: service_counter_bank

Overview:
Bank of CNTER service windows. It sits on the far side of the dispatcher's load interface (ld/dn/dt) and returns busy.
- On a load pulse, a lane latches the ticket number and the service time.
- The lane counts the service time down in prescaled time units, then signals completion and releases busy.
- Every output is registered. Lanes are fully independent and share one tick prescaler.

Parameters:
DT_SZ, 4, width of ticket number and service-time fields per lane
CNTER, 3, number of service lanes
TICK_DIV, 4, clk cycles per service-time unit (≥2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-high (asserted when 1)
ld  input  CNTER  per-lane load strobe, 1-cycle pulse
dn  input  CNTER*DT_SZ  ticket number; lane i = dn[i*DT_SZ +: DT_SZ]
dt  input  CNTER*DT_SZ  service time in units; lane i slice as dn
busy  output  CNTER  lane occupied (SERVE or DONE)
done  output  CNTER  1-cycle pulse when a lane finishes
cur_num  output  CNTER*DT_SZ  ticket currently served; holds last value after done
remain  output  CNTER*DT_SZ  remaining service units

Behaviour:
- Reset (rst_n=1, async):
  - all lanes go to IDLE;
  - busy, done, cur_num and remain are all 0;
  - the prescaler is cleared to 0.
- Prescaler:
  - free-running 0..TICK_DIV-1 after reset;
  - internal tick is high in the cycle where count==TICK_DIV-1.
- Per-lane FSM, states IDLE, SERVE, DONE:
  - IDLE & ld[i]:
    - latch dn/dt slices into cur_num/remain;
    - if dt!=0, go to SERVE, else go to DONE.
  - SERVE & tick: remain-1. When remain==1 at the tick, remain becomes 0 and the state goes to DONE.
  - DONE: done[i]=1 for exactly this cycle, then IDLE.
- busy[i] is registered:
  - it is 1 in the cycle after the ld edge, so the dispatcher never double-loads;
  - it returns to 0 the cycle after the done pulse.
- SERVE duration is between (dt-1)*TICK_DIV+1 and dt*TICK_DIV cycles, depending on prescaler phase. Max dt = 2^DT_SZ-1; no wrap.
- ld[i] in SERVE or DONE: ignored; lane state is unchanged.
- ld[i] in the same cycle the lane goes DONE→IDLE: ignored; the load is accepted only in IDLE.
- Multiple ld bits in one cycle: each lane loads independently.
- Reset mid-service: the lane aborts immediately and no done pulse is generated.

Optional Feature:
SVC_OVERLOAD_DET_EN
- Defined:
  - adds output ld_err (CNTER, sticky);
  - ld_err[i] is set the cycle after ld[i] arrives while lane i is not IDLE;
  - cleared only by reset.
- Undefined: the port and logic are absent, and ignored loads are silent.

Decomposition:
- Package svc_pkg:
  - lane state enum {IDLE, SERVE, DONE};
  - default DT_SZ/CNTER/TICK_DIV localparams;
  - slice helper function.
- Sub-module service_lane: one FSM/countdown per lane, instantiated CNTER times in a generate loop.
- The top level holds the prescaler and the port slicing.

Test Plan:
(All scenarios use DT_SZ=4, CNTER=3, TICK_DIV=4.)
1. Reset held, ld=3'b111 → busy=0, done=0, cur_num=0, remain=0; after release, prescaler tick every 4 cycles.
2. ld=3'b001, dn0=11, dt0=2 → busy[0]=1 next cycle; cur_num0=11; remain 2→1→0 on ticks; done[0] one pulse; busy[0]=0 next cycle; SERVE lasts 5..8 cycles.
3. ld=3'b010, dt1=0, dn1=5 → DONE directly; busy[1] high 1 cycle, done[1] pulse, cur_num1=5.
4. Lane 2 loaded dt=3; re-pulse ld[2] with dn=9 mid-service → cur_num2 unchanged, remain continues; ld_err[2]=1 if SVC_OVERLOAD_DET_EN.
5. ld=3'b111 with dt=1,2,3 simultaneously → done pulses in lane order 0,1,2, each one tick apart.
6. Assert rst_n mid-SERVE on lane 0 (remain=2) → busy/remain clear asynchronously, no done pulse; reload after release works normally.
